// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I pipeline control blocks.
//   - opcode constants for the instruction classes the hazard logic inspects
//   - hazard controller state encoding
//   - helpers that decode which source registers an opcode actually reads
package riscv_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_NOP    = 7'b0000000;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HOLD = 2'd1,
      ST_ERR  = 2'd2
   } hz_state_e;

   function automatic logic uses_rs1(input logic [6:0] op);
      case (op)
         OP_LOAD, OP_STORE, OP_RTYPE,
         OP_ITYPE, OP_BRANCH, OP_JALR: uses_rs1 = 1'b1;
         OP_NOP:                       uses_rs1 = 1'b0;
         default:                      uses_rs1 = 1'b0;
      endcase
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      case (op)
         OP_STORE, OP_RTYPE, OP_BRANCH: uses_rs2 = 1'b1;
         default:                       uses_rs2 = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset : clock, async active-high reset (clears count)
//   inc        : count up by one this cycle (holds at all-ones)
//   clr        : synchronous clear, wins over inc
//   q          : current count
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != '1))
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign q = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core.
// Generates the control_path bubble select, PC / IF-ID enables, IF-ID flush
// and the back-end hold; watches memory wait time and counts hazard events.
//
// state | meaning
// RUN   | normal issue; branch flush / load-use stall resolved combinationally
// HOLD  | data memory busy, pipeline frozen, busy cycles being counted
// ERR   | memory wait exceeded TIMEOUT; frozen until reset
//
// Ports:
//   clk, reset                 : clock, async active-high reset
//   id_opcode/id_rs1/id_rs2    : instruction fields in ID
//   ex_mem_read, ex_rd         : ID/EX MemRead and destination
//   ex_branch_taken            : branch resolved taken in EX
//   mem_busy                   : data memory not ready
//   clr_cnt                    : synchronous clear of performance counters
//   pc_write, ifid_write       : fetch-side enables
//   ifid_flush, ctrl_sel       : IF/ID nop insert, ID/EX bubble select
//   pipe_hold                  : hold ID/EX, EX/MEM, MEM/WB
//   mem_timeout                : sticky watchdog error
//   lu_cnt/flush_cnt/hold_cnt  : saturating event counters
module hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       id_opcode,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             ex_branch_taken,
   input  logic             mem_busy,
   input  logic             clr_cnt,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             ctrl_sel,
   output logic             pipe_hold,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] lu_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] hold_cnt
);

   localparam int BW = $clog2(TIMEOUT + 1);

   hz_state_e state_q, state_d;
   logic [BW-1:0] busy_q, busy_d;
   logic tmo_q, tmo_d;
   logic load_use, run_rules, lu_inc, fl_inc;

   assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                     ((uses_rs1(id_opcode) && (id_rs1 == ex_rd)) ||
                      (uses_rs2(id_opcode) && (id_rs2 == ex_rd)));

   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      tmo_d      = tmo_q;
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      ctrl_sel   = 1'b0;
      pipe_hold  = 1'b0;
      lu_inc     = 1'b0;
      fl_inc     = 1'b0;
      run_rules  = 1'b0;

      case (state_q)
         ST_RUN: run_rules = 1'b1;
         ST_HOLD: begin
            if (mem_busy) begin
               pipe_hold  = 1'b1;
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               busy_d     = busy_q + BW'(1);
               // this cycle is wait number TIMEOUT
               if (busy_q == BW'(TIMEOUT - 1)) begin
                  state_d = ST_ERR;
                  tmo_d   = 1'b1;
               end
            end else begin
               // memory released: act on pending branch/load-use right away
               state_d   = ST_RUN;
               busy_d    = '0;
               run_rules = 1'b1;
            end
         end
         ST_ERR: begin
            pipe_hold  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
         end
         default: state_d = ST_RUN;
      endcase

      if (run_rules) begin
         if (mem_busy) begin
            pipe_hold  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            state_d    = ST_HOLD;
            busy_d     = BW'(1);
         end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            ctrl_sel   = 1'b1;
            fl_inc     = 1'b1;
         end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ctrl_sel   = 1'b1;
            lu_inc     = 1'b1;
         end
      end

      // outputs are forced safe while reset is held, independent of inputs
      if (reset) begin
         pc_write   = 1'b1;
         ifid_write = 1'b1;
         ifid_flush = 1'b0;
         ctrl_sel   = 1'b0;
         pipe_hold  = 1'b0;
         lu_inc     = 1'b0;
         fl_inc     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
         busy_q  <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         tmo_q   <= tmo_d;
      end
   end

   assign mem_timeout = tmo_q;

   sat_counter #(.W(CNT_W)) u_lu_cnt (
      .clk(clk), .reset(reset), .inc(lu_inc), .clr(clr_cnt), .q(lu_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk(clk), .reset(reset), .inc(fl_inc), .clr(clr_cnt), .q(flush_cnt)
   );

   sat_counter #(.W(CNT_W)) u_hold_cnt (
      .clk(clk), .reset(reset), .inc(pipe_hold), .clr(clr_cnt), .q(hold_cnt)
   );

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core. It generates the `sel` bubble input consumed by `control_path`, plus the PC, IF/ID and pipeline-hold enables.
- Detects load-use hazards, flushes on branches taken in EX, and freezes the pipeline while data memory is busy. A memory-wait watchdog raises a sticky timeout error.
- Keeps saturating performance counters for stalls, flushes and hold cycles.

Parameters:
- TIMEOUT, 64, maximum consecutive mem_busy cycles before the error is raised (must be ≥ 2).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- id_opcode  input  7  opcode of the instruction in ID.
- id_rs1  input  5  rs1 field in ID.
- id_rs2  input  5  rs2 field in ID.
- ex_mem_read  input  1  ID/EX MemRead.
- ex_rd  input  5  ID/EX destination register.
- ex_branch_taken  input  1  branch resolved taken in EX this cycle.
- mem_busy  input  1  data memory not ready; MEM cannot complete.
- clr_cnt  input  1  synchronous clear of all performance counters.
- pc_write  output  1  PC update enable.
- ifid_write  output  1  IF/ID register enable.
- ifid_flush  output  1  IF/ID becomes nop (opcode 0).
- ctrl_sel  output  1  drives `control_path` sel; 1 forces all-zero control into ID/EX (bubble).
- pipe_hold  output  1  holds ID/EX, EX/MEM and MEM/WB.
- mem_timeout  output  1  sticky watchdog error.
- lu_cnt  output  CNT_W  load-use stall cycles.
- flush_cnt  output  CNT_W  branch flushes.
- hold_cnt  output  CNT_W  mem_busy hold cycles.

Behaviour:
- Reset state: FSM=RUN, busy counter=0, all counters=0, mem_timeout=0. Control outputs during reset are driven to pc_write=1, ifid_write=1, ifid_flush=0, ctrl_sel=0, pipe_hold=0.
- Register usage, decoded from id_opcode:
  - rs1 is used for opcodes 0000011, 0100011, 0110011, 0010011, 1100011, 1100111.
  - rs2 is used for opcodes 0100011, 0110011, 1100011.
  - Any other opcode, including 0000000 (nop), uses neither.
  - Register x0 never causes a hazard.
- load_use = ex_mem_read & ex_rd≠0 & ((rs1 used & id_rs1==ex_rd) | (rs2 used & id_rs2==ex_rd)).
- FSM states: RUN, HOLD, ERR. Control outputs are combinational from state and inputs, so they take effect in the same cycle (zero latency).
- RUN, in priority order:
  1. mem_busy=1: pipe_hold=1, pc_write=0, ifid_write=0, ctrl_sel=0, ifid_flush=0; next state HOLD; busy counter←1.
  2. Else ex_branch_taken=1: ifid_flush=1 and ctrl_sel=1; pc_write=1; ifid_write=1. flush_cnt increments. The branch has priority over a simultaneous load_use.
  3. Else load_use=1: pc_write=0, ifid_write=0, ctrl_sel=1. lu_cnt increments. The stall lasts exactly one cycle because ID/EX then holds a bubble and ex_mem_read=0.
  4. Else: all enables at their reset values.
- HOLD:
  - Outputs are the same as RUN case 1 while mem_busy=1; busy counter increments every cycle.
  - When mem_busy=0: return to RUN and evaluate RUN rules in that same cycle, so a pending branch or load-use is acted on then. Busy counter←0.
  - When the busy counter reaches TIMEOUT with mem_busy still 1: go to ERR and set mem_timeout=1.
- ERR:
  - Pipeline stays fully frozen (pipe_hold=1, pc_write=0, ifid_write=0) regardless of inputs.
  - Only reset exits ERR.
- hold_cnt increments in every cycle with pipe_hold=1, including in ERR.
- Counters saturate at 2^CNT_W−1 (no wrap).
- clr_cnt=1 zeroes all counters and overrides any increment in that cycle. It does not affect FSM state or mem_timeout.
- Reset asserted mid-HOLD or in ERR returns to RUN immediately (asynchronous).

Decomposition:
- Shared package `riscv_pkg`:
  - opcode localparams: OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JALR, OP_NOP.
  - FSM state encoding: RUN, HOLD, ERR.
- Sub-module `sat_counter` (parameter W; ports inc, clr, q), instantiated three times for the performance counters.

Test Plan:
- Load-use on rs1: ex_mem_read=1, ex_rd=5, id_opcode=0110011, id_rs1=5.
  - Cycle 1: pc_write=0, ifid_write=0, ctrl_sel=1, lu_cnt=1.
  - Next cycle (ex_mem_read=0): all enables return to their reset values.
- x0 and rs2-unused cases, each with ex_mem_read=1:
  - ex_rd=0, id_rs1=0: no stall.
  - id_opcode=0010011, id_rs2=ex_rd=7: no stall.
  - id_opcode=0100011, id_rs2=7: stall.
- Branch and load-use in the same cycle: ex_branch_taken=1 together with a load_use condition → ifid_flush=1, ctrl_sel=1, pc_write=1; flush_cnt=1, lu_cnt=0.
- mem_busy held for 3 cycles, branch asserted throughout:
  - 3 cycles with pipe_hold=1; hold_cnt=3.
  - Cycle 4: flush applied, FSM back in RUN.
- Watchdog with TIMEOUT=4: mem_busy held for 10 cycles → mem_timeout=1 after cycle 4 and the pipeline stays frozen after mem_busy drops. Asserting reset mid-ERR → mem_timeout=0, FSM=RUN.
- Saturation with CNT_W=2: 5 load-use stalls → lu_cnt=3. Then clr_cnt=1 while a stall is active → lu_cnt=0.
